inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Producer side of the decoder's 32-bit instruction-word interface for the miniRV core.
//  Holds the PC and fetches one word at a time from instruction memory over a req/rsp handshake.
//  Presents each word plus its PC to the decode stage with valid/ready, and accepts PC redirects.
//  Stops fetching after an EBREAK word (32'h0010_0073) is handed off.
// PARAMETERS
//  RESET_PC   32'h8000_0000   PC of first fetch after reset; bits[1:0] must be 0
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request this cycle
//  imem_addr      out  32  word-aligned fetch address (= pc)
//  imem_rsp_valid in   1   read data valid; exactly one per accepted request, >=1 cycle later
//  imem_rsp_data  in   32  instruction word
//  inst_valid     out  1   instruction/inst_pc valid to decoder
//  inst_ready     in   1   decoder consumes word this cycle
//  instruction    out  32  fetched word
//  inst_pc        out  32  address of instruction
//  redirect_valid in   1   branch/jump redirect, single-cycle pulse
//  redirect_pc    in   32  redirect target; bits[1:0] ignored (treated as 0)
//  halted         out  1   EBREAK delivered; fetch stopped until reset
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): pc=RESET_PC, state=REQ, drop=0; all outputs 0
//   except imem_addr=RESET_PC. First imem_req_valid=1 in the first cycle after rst_n rises.
//  States: REQ, WAIT, HOLD, HALT. At most one outstanding memory request.
//  REQ : imem_req_valid=1, imem_addr=pc (held stable until accepted).
//        req_valid&req_ready -> WAIT. Redirect while in REQ (accepted or not): pc<=redirect_pc;
//        if request accepted same cycle -> WAIT with drop=1, else stay REQ with new address.
//  WAIT: rsp_valid&!drop -> HOLD; instruction<=rsp_data, inst_pc<=pc, pc<=pc+4, inst_valid=1
//        from next cycle. rsp_valid&drop -> discard, drop<=0, REQ.
//        Redirect in WAIT: pc<=redirect_pc, drop<=1 (response discarded when it arrives).
//        Redirect coincident with rsp_valid: response discarded, pc<=redirect_pc, -> REQ.
//  HOLD: inst_valid=1; instruction/inst_pc stable while !inst_ready.
//        inst_valid&inst_ready: if instruction==EBREAK -> HALT, else -> REQ (one-cycle bubble;
//        no fetch overlap). Redirect in HOLD (with or without inst_ready): word is withdrawn
//        (inst_valid=0 next cycle), pc<=redirect_pc, -> REQ; redirect wins over EBREAK handoff.
//  HALT: halted=1, imem_req_valid=0, inst_valid=0; redirects ignored; exit only via rst_n.
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000 silently.
//  Throughput: one instruction per (2 + memory latency + decoder stall) cycles minimum.
//  Reset mid-operation: in-flight response after reset is not expected; memory is reset too.
//  Outputs registered except imem_req_valid/imem_addr (decoded from state/pc registers).
// STRUCTURE
//  Shared package miniRV_pkg: EBREAK_WORD=32'h0010_0073, fetch state enum (REQ/WAIT/HOLD/HALT),
//   default RESET_PC, instruction width constant. Same EBREAK_WORD used by decoder.
//  Single module; no sub-module needed (PC register + FSM + output register only).
// TESTING
//  1 Reset, mem 1-cycle latency, inst_ready=1, words at 0x8000_0000.. -> inst_pc sequence
//    0x8000_0000, 0x8000_0004, 0x8000_0008; first req_valid 1 cycle after rst_n rises.
//  2 inst_ready=0 for 5 cycles in HOLD -> instruction/inst_pc stable, no new imem_req_valid.
//  3 redirect_pc=0x8000_0100 while WAIT, rsp 3 cycles later -> that rsp never on instruction;
//    next imem_addr=0x8000_0100, next inst_pc=0x8000_0100.
//  4 redirect coincident with imem_rsp_valid -> rsp dropped; redirect in HOLD -> inst_valid
//    falls next cycle, refetch from target.
//  5 word 32'h0010_0073 at 0x8000_000C -> delivered with inst_pc=0x8000_000C, halted=1 after
//    handshake, no further imem_req_valid; redirect pulse ignored; rst_n low clears halted.
//  6 imem_req_ready low 4 cycles -> imem_addr stable; redirect during stall changes address.

Source files
------------

// File: rtl/miniRV_pkg.sv
// miniRV_pkg: constants and types shared by the miniRV front end.
//   EBREAK_WORD      - instruction word that stops fetch once handed to decode
//   DEFAULT_RESET_PC - PC of the first fetch after reset
//   fetch_state_t    - instruction fetch FSM states
package miniRV_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] EBREAK_WORD      = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundle of the fetch unit's handshakes.
//   imem_req_valid/ready, imem_addr   - request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data     - response channel from instruction memory
//   inst_valid/ready, instruction,
//   inst_pc                           - word handed to the decode stage
//   redirect_valid, redirect_pc       - PC redirect from the execute stage
//   halted                            - fetch stopped after EBREAK
// master = fetch unit, slave = its environment (memory, decoder, redirect source).
interface inst_fetch_if;
  import miniRV_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [31:0]       imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] instruction;
  logic [31:0]       inst_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halted;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, instruction, inst_pc, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, instruction, inst_pc, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: miniRV instruction fetch unit. Holds the PC, fetches one word at a
// time from instruction memory and offers it to decode with valid/ready.
// Accepts PC redirects and stops for good after an EBREAK is handed off.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - inst_fetch_if.master (memory req/rsp, decode handshake, redirect, halted)
//
// state  | meaning
// S_REQ  | request pending on imem, address = pc
// S_WAIT | one request outstanding, waiting for its response
// S_HOLD | word valid toward decode, waiting for inst_ready
// S_HALT | EBREAK delivered, idle until reset
module inst_fetch
  import miniRV_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              halted_q, halted_d;
  // Keeps the request low while reset is held and in the cycle rst_n rises,
  // so the first request appears one cycle after reset release.
  logic              started_q;

  logic              req_valid;
  logic              req_fire;
  logic [31:0]       redir_pc;

  assign req_valid = started_q && (state_q == S_REQ);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign redir_pc  = word_align(bus.redirect_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      instr_q      <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      instr_q      <= instr_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      started_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    instr_d      = instr_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          // The request just accepted carries the stale address.
          if (req_fire) begin
            drop_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.redirect_valid) begin
            pc_d    = redir_pc;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d      = bus.imem_rsp_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        // A redirect withdraws the word even if decode is taking it now.
        if (bus.redirect_valid) begin
          pc_d         = redir_pc;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (bus.inst_ready) begin
          inst_valid_d = 1'b0;
          if (instr_q == EBREAK_WORD) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_HALT: begin
        inst_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.instruction    = instr_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.halted         = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a cycle-stepped memory model.
module tb_inst_fetch;
  import miniRV_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // memory / environment model state
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_left;
  int          lat = 1;
  int          stall_left = 0;
  bit          redir_req;
  logic [31:0] redir_tgt;
  bit          dec_ready = 1'b1;
  bit          eb_en;
  logic [31:0] eb_addr;

  // per-cycle observations
  bit          accepted;
  logic [31:0] acc_addr;
  bit          handed;
  logic [31:0] hand_pc;
  logic [31:0] hand_instr;
  int          req_count;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } redir_vec_t;

  redir_vec_t vecs [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (eb_en && a == eb_addr) return EBREAK_WORD;
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, want event", name);
  endtask

  // One clock: drive inputs at negedge, observe handshakes, update memory after posedge.
  task automatic cyc();
    @(negedge clk);
    bus.imem_rsp_valid = pend && (pend_left == 0);
    bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(pend_addr) : 32'h0;
    bus.imem_req_ready = (stall_left == 0);
    bus.redirect_valid = redir_req;
    bus.redirect_pc    = redir_tgt;
    bus.inst_ready     = dec_ready;
    #1;
    accepted   = bus.imem_req_valid && bus.imem_req_ready;
    acc_addr   = bus.imem_addr;
    handed     = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    hand_pc    = bus.inst_pc;
    hand_instr = bus.instruction;
    if (bus.imem_req_valid) req_count++;
    @(posedge clk);
    if (bus.imem_rsp_valid) pend = 1'b0;
    if (accepted) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_left = lat - 1;
    end else if (pend && pend_left > 0) begin
      pend_left--;
    end
    if (stall_left > 0) stall_left--;
    redir_req = 1'b0;
    #1;
  endtask

  task automatic wait_accept(output logic [31:0] a);
    a = '0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (accepted) begin
        a = acc_addr;
        return;
      end
    end
    timeout("accept");
  endtask

  task automatic wait_handoff(output logic [31:0] pc, output logic [31:0] ins);
    pc  = '0;
    ins = '0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (handed) begin
        pc  = hand_pc;
        ins = hand_instr;
        return;
      end
    end
    timeout("handoff");
  endtask

  task automatic wait_inst_valid();
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (bus.inst_valid) return;
    end
    timeout("inst_valid");
  endtask

  task automatic expect_handoff(input string name, input logic [31:0] exp_pc);
    logic [31:0] pc, ins;
    wait_handoff(pc, ins);
    check({name, " pc"}, pc, exp_pc);
    check({name, " instr"}, ins, mem_word(exp_pc));
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    pend               = 1'b0;
    pend_left          = 0;
    stall_left         = 0;
    redir_req          = 1'b0;
    redir_tgt          = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = dec_ready;
    repeat (2) @(posedge clk);
    #1;
    check("rst req_valid", bus.imem_req_valid, 0);
    check("rst addr", bus.imem_addr, RPC);
    check("rst inst_valid", bus.inst_valid, 0);
    check("rst halted", bus.halted, 0);
    check("rst instruction", bus.instruction, 0);
    check("rst inst_pc", bus.inst_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_valid at release", bus.imem_req_valid, 0);
    @(posedge clk);
    #1;
    check("first req_valid", bus.imem_req_valid, 1);
    check("first addr", bus.imem_addr, RPC);
  endtask

  initial begin
    logic [31:0] a, pc, ins;

    vecs[0] = '{target: 32'h8000_0100, lat: 3, exp_a: 32'h8000_0100, exp_b: 32'h8000_0104};
    vecs[1] = '{target: 32'h8000_0202, lat: 2, exp_a: 32'h8000_0200, exp_b: 32'h8000_0204};
    vecs[2] = '{target: 32'hFFFF_FFFF, lat: 4, exp_a: 32'hFFFF_FFFC, exp_b: 32'h0000_0000};
    vecs[3] = '{target: 32'h0000_0010, lat: 2, exp_a: 32'h0000_0010, exp_b: 32'h0000_0014};

    eb_en   = 1'b0;
    eb_addr = 32'h8000_000C;

    // sequential fetch, 1-cycle memory
    lat = 1; dec_ready = 1'b1;
    do_reset();
    expect_handoff("seq0", RPC);
    expect_handoff("seq1", RPC + 32'd4);
    expect_handoff("seq2", RPC + 32'd8);

    // decoder stall holds the word and blocks fetch
    dec_ready = 1'b0;
    do_reset();
    wait_inst_valid();
    check("stall inst_pc", bus.inst_pc, RPC);
    req_count = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall inst_valid", bus.inst_valid, 1);
      check("stall instruction", bus.instruction, mem_word(RPC));
      check("stall inst_pc held", bus.inst_pc, RPC);
    end
    check("stall no req", req_count, 0);
    dec_ready = 1'b1;
    expect_handoff("after stall", RPC);
    expect_handoff("after stall next", RPC + 32'd4);

    // redirect while a request is outstanding
    for (int v = 0; v < 4; v++) begin
      do_reset();
      lat = vecs[v].lat;
      expect_handoff("vec first", RPC);
      wait_accept(a);
      check("vec stale addr", a, RPC + 32'd4);
      redir_req = 1'b1;
      redir_tgt = vecs[v].target;
      cyc();
      wait_accept(a);
      check("vec new addr", a, vecs[v].exp_a);
      expect_handoff("vec target", vecs[v].exp_a);
      expect_handoff("vec target+4", vecs[v].exp_b);
    end

    // redirect coincident with response
    lat = 3;
    do_reset();
    expect_handoff("coinc first", RPC);
    wait_accept(a);
    for (int n = 0; n < 10 && !(pend && pend_left == 0); n++) cyc();
    redir_req = 1'b1;
    redir_tgt = 32'h8000_0300;
    cyc();
    wait_accept(a);
    check("coinc new addr", a, 32'h8000_0300);
    expect_handoff("coinc target", 32'h8000_0300);
    expect_handoff("coinc target+4", 32'h8000_0304);

    // redirect while holding a word withdraws it
    dec_ready = 1'b0;
    wait_inst_valid();
    check("hold inst_pc", bus.inst_pc, 32'h8000_0308);
    dec_ready = 1'b1;
    redir_req = 1'b1;
    redir_tgt = 32'h8000_0400;
    cyc();
    check("hold withdrawn", bus.inst_valid, 0);
    check("hold no handoff", handed, 0);
    expect_handoff("hold target", 32'h8000_0400);

    // EBREAK handoff halts fetch
    lat = 1; eb_en = 1'b1;
    do_reset();
    expect_handoff("eb w0", RPC);
    expect_handoff("eb w1", RPC + 32'd4);
    expect_handoff("eb w2", RPC + 32'd8);
    wait_handoff(pc, ins);
    check("eb pc", pc, 32'h8000_000C);
    check("eb instr", ins, EBREAK_WORD);
    check("eb halted", bus.halted, 1);
    check("eb inst_valid", bus.inst_valid, 0);
    check("eb req_valid", bus.imem_req_valid, 0);
    req_count = 0;
    redir_req = 1'b1;
    redir_tgt = RPC;
    repeat (6) cyc();
    check("halt no req", req_count, 0);
    check("halt stays", bus.halted, 1);
    check("halt no inst", bus.inst_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("halt cleared by reset", bus.halted, 0);

    // redirect beats EBREAK handoff
    do_reset();
    expect_handoff("ebr w0", RPC);
    expect_handoff("ebr w1", RPC + 32'd4);
    expect_handoff("ebr w2", RPC + 32'd8);
    dec_ready = 1'b0;
    wait_inst_valid();
    check("ebr held instr", bus.instruction, EBREAK_WORD);
    dec_ready = 1'b1;
    redir_req = 1'b1;
    redir_tgt = 32'h8000_0010;
    cyc();
    check("ebr not halted", bus.halted, 0);
    expect_handoff("ebr target", 32'h8000_0010);
    eb_en = 1'b0;

    // memory not ready: address stable, redirect retargets pending request
    do_reset();
    stall_left = 4;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mstall req_valid", bus.imem_req_valid, 1);
      check("mstall addr", bus.imem_addr, RPC);
    end
    expect_handoff("mstall word", RPC);
    stall_left = 4;
    cyc();
    check("mstall2 addr", bus.imem_addr, RPC + 32'd4);
    redir_req = 1'b1;
    redir_tgt = 32'h8000_0500;
    cyc();
    check("mstall2 req_valid", bus.imem_req_valid, 1);
    check("mstall2 new addr", bus.imem_addr, 32'h8000_0500);
    expect_handoff("mstall2 target", 32'h8000_0500);

    // redirect in the same cycle the request is accepted
    redir_req = 1'b1;
    redir_tgt = 32'h8000_0600;
    cyc();
    check("reqacc accepted", accepted, 1);
    check("reqacc stale addr", acc_addr, 32'h8000_0504);
    expect_handoff("reqacc target", 32'h8000_0600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got hang, want finish");
    $fatal(1);
  end

endmodule
